// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - DEPTH-entry IF/ID instruction buffer with valid/ready handshake and flush
// Head entry feeds ID; an empty queue presents an all-zero NOP bubble.
module if_id_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int PC_INC = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] instruction,
  input  logic [ADDR_W-1:0] pc,
  output logic              if_ready,
  input  logic              flush,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] if_id_instruction,
  output logic [ADDR_W-1:0] if_id_pc_plus4,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [DATA_W-1:0] instr_mem_d [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic push;
  logic pop;
  logic empty;
  logic full;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // Handshake outputs look only at registered state, never at same-cycle inputs.
  assign if_ready = ~full;
  assign id_valid = ~empty;
  assign count    = count_q;

  assign push = if_valid & ~full & ~flush;
  assign pop  = ~empty & id_ready & ~flush;

  always_comb begin
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (flush) begin
      // Stored data is left in place; outputs are masked while empty.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        instr_mem_d[wr_ptr_q] = instruction;
        pc_mem_d[wr_ptr_q]    = pc + ADDR_W'(PC_INC);
        wr_ptr_d              = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

  always_comb begin
    if_id_instruction = '0;
    if_id_pc_plus4    = '0;
    if (!empty) begin
      if_id_instruction = instr_mem_q[rd_ptr_q];
      if_id_pc_plus4    = pc_mem_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - randomized and directed self-checking bench for if_id_queue
module tb_if_id_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int PC_INC = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_valid;
  logic [DATA_W-1:0] instruction;
  logic [ADDR_W-1:0] pc;
  logic              if_ready;
  logic              flush;
  logic              id_ready;
  logic              id_valid;
  logic [DATA_W-1:0] if_id_instruction;
  logic [ADDR_W-1:0] if_id_pc_plus4;
  logic [CNT_W-1:0]  count;

  if_id_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PC_INC(PC_INC)
  ) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .instruction(instruction),
    .pc(pc), .if_ready(if_ready), .flush(flush), .id_ready(id_ready),
    .id_valid(id_valid), .if_id_instruction(if_id_instruction),
    .if_id_pc_plus4(if_id_pc_plus4), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] pc4;
    logic [DATA_W-1:0] ins;
  } ent_t;

  ent_t mq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("count", 64'(count), 64'(mq.size()));
    check("id_valid", 64'(id_valid), 64'(mq.size() != 0));
    check("if_ready", 64'(if_ready), 64'(mq.size() != DEPTH));
    if (mq.size() == 0) begin
      check("nop_instr", 64'(if_id_instruction), 64'd0);
      check("nop_pc", 64'(if_id_pc_plus4), 64'd0);
    end else begin
      check("head_instr", 64'(if_id_instruction), 64'(mq[0].ins));
      check("head_pc", 64'(if_id_pc_plus4), 64'(mq[0].pc4));
    end
  endtask

  task automatic drive(input logic iv, input logic [DATA_W-1:0] ins,
                       input logic [ADDR_W-1:0] p, input logic fl, input logic idr);
    if_valid    = iv;
    instruction = ins;
    pc          = p;
    flush       = fl;
    id_ready    = idr;
  endtask

  // One clock: decide the transfer from the model's occupancy, update it, check after the edge.
  task automatic cycle();
    bit   do_push, do_pop;
    ent_t e;
    do_push = if_valid && (mq.size() < DEPTH) && !flush;
    do_pop  = (mq.size() > 0) && id_ready && !flush;
    e.pc4   = pc + ADDR_W'(PC_INC);
    e.ins   = instruction;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) cycle();
  endtask

  initial begin
    int k;
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_outputs();

    // Streaming: each instruction visible one cycle after its push.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA000_0000 + i, 32'h100 + 4 * i, 1'b0, 1'b1);
      cycle();
      check("stream_pc", 64'(if_id_pc_plus4), 64'(32'h104 + 4 * i));
      check("stream_cnt_le1", 64'(count <= 1), 64'd1);
    end
    drain();

    // Fill while ID stalls; an instruction is only advanced when IF sees it accepted.
    k = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1'b1, 32'hB000_0000 + k, 32'h200 + 4 * k, 1'b0, 1'b0);
      if (if_ready) k++;
      cycle();
    end
    check("fill_count", 64'(count), 64'(DEPTH));
    check("fill_if_ready", 64'(if_ready), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    for (int j = 0; j < DEPTH; j++) begin
      check("drain_order", 64'(if_id_pc_plus4), 64'(32'h204 + 4 * j));
      cycle();
    end
    check("drain_empty", 64'(id_valid), 64'd0);

    // Full with simultaneous pop: no pass-through, push accepted next cycle.
    drive(1'b1, 32'hC0, 32'h400, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      pc = 32'h400 + 4 * i;
      cycle();
    end
    drive(1'b1, 32'hC9, 32'h480, 1'b0, 1'b1);
    cycle();
    check("full_pop_count", 64'(count), 64'(DEPTH - 1));
    cycle();
    check("full_next_push", 64'(count), 64'(DEPTH - 1));
    drain();

    // Flush with push and pop requested in the same cycle.
    drive(1'b1, 32'hD0, 32'h500, 1'b0, 1'b0);
    cycle();
    pc = 32'h504;
    cycle();
    drive(1'b1, 32'hDEAD, 32'h600, 1'b1, 1'b1);
    cycle();
    check("flush_count", 64'(count), 64'd0);
    check("flush_pc", 64'(if_id_pc_plus4), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("flush_no_deliver", 64'(id_valid), 64'd0);
    end

    // PC wraps modulo 2^ADDR_W.
    drive(1'b1, 32'hE0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    cycle();
    check("wrap_pc", 64'(if_id_pc_plus4), 64'd0);
    check("wrap_valid", 64'(id_valid), 64'd1);
    drain();

    // Asynchronous reset mid-stream with three entries held.
    drive(1'b1, 32'hF0, 32'h700, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pc = 32'h700 + 4 * i;
      cycle();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_if_ready", 64'(if_ready), 64'd1);
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_instr", 64'(if_id_instruction), 64'd0);
    check("rst_pc", 64'(if_id_pc_plus4), 64'd0);
    mq.delete();
    @(negedge clk);
    reset = 1'b0;
    check_outputs();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, $urandom, $urandom & 32'hFFFF_FFFC,
            ($urandom % 20) == 0, ($urandom % 3) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
